rob_multiport: RTL and testbench

//  Parametrised reorder buffer with a circular queue of 2^ROB_DEPTH_BIT entries.
//  - Accepts one dispatched instruction per cycle from the Decoder.
//  - Takes WB_PORTS writeback results per cycle from the RS/LSB/ALU execute ends.
//  - Retires one instruction per cycle in program order.
//  - Stores commit through a valid/ack handshake with the LSB.
//  - A mispredicted branch at the head raises a one-cycle flush with the correct PC.

---
 rtl/rob_multiport.sv | 193 +++++++++++++++++++
 tb/tb_rob_multiport.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_multiport.sv
// Reorder buffer: circular queue of 2^ROB_DEPTH_BIT entries, one dispatch and one in-order retire per
// cycle, WB_PORTS writebacks per cycle, store handshake with the LSB and a one-cycle mispredict flush.
module rob_multiport #(
  parameter int ROB_DEPTH_BIT = 4,
  parameter int WB_PORTS      = 2,
  parameter int XLEN          = 32
) (
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic                              rdy_in,
  input  logic                              disp_valid,
  output logic                              disp_ready,
  output logic [ROB_DEPTH_BIT-1:0]          disp_tag,
  input  logic [1:0]                        disp_type,
  input  logic [4:0]                        disp_rd,
  input  logic                              disp_done,
  input  logic [XLEN-1:0]                   disp_val,
  input  logic                              disp_pred,
  input  logic [XLEN-1:0]                   disp_alt_pc,
  input  logic [WB_PORTS-1:0]               wb_valid,
  input  logic [WB_PORTS*ROB_DEPTH_BIT-1:0] wb_tag,
  input  logic [WB_PORTS*XLEN-1:0]          wb_val,
  output logic                              cmt_valid,
  output logic [4:0]                        cmt_rd,
  output logic [XLEN-1:0]                   cmt_val,
  output logic [ROB_DEPTH_BIT-1:0]          cmt_tag,
  output logic                              st_cmt_valid,
  output logic [ROB_DEPTH_BIT-1:0]          st_cmt_tag,
  input  logic                              st_cmt_ack,
  input  logic [ROB_DEPTH_BIT-1:0]          q1_tag,
  input  logic [ROB_DEPTH_BIT-1:0]          q2_tag,
  output logic                              q1_ready,
  output logic                              q2_ready,
  output logic [XLEN-1:0]                   q1_val,
  output logic [XLEN-1:0]                   q2_val,
  output logic                              flush_out,
  output logic [XLEN-1:0]                   flush_pc,
  output logic [ROB_DEPTH_BIT:0]            count
);

  localparam int DEPTH = 1 << ROB_DEPTH_BIT;
  localparam logic [ROB_DEPTH_BIT:0] FULL_COUNT = (ROB_DEPTH_BIT + 1)'(DEPTH);
  localparam logic [1:0] TYPE_RD     = 2'd0;
  localparam logic [1:0] TYPE_STORE  = 2'd1;
  localparam logic [1:0] TYPE_BRANCH = 2'd2;

  typedef logic [ROB_DEPTH_BIT-1:0] tag_t;

  logic [DEPTH-1:0] busy_reg;
  logic [DEPTH-1:0] ready_reg;
  logic [DEPTH-1:0] pred_reg;
  logic [1:0]       type_reg   [DEPTH];
  logic [4:0]       rd_reg     [DEPTH];
  logic [XLEN-1:0]  val_reg    [DEPTH];
  logic [XLEN-1:0]  alt_pc_reg [DEPTH];

  tag_t                   head_reg;
  tag_t                   tail_reg;
  logic [ROB_DEPTH_BIT:0] count_reg;
  logic                   flush_reg;
  logic [XLEN-1:0]        flush_pc_reg;

  // Nothing moves while stalled, and the flush cycle swallows dispatch, writeback and retire.
  logic active;
  assign active = rdy_in & ~flush_reg;

  tag_t            wb_tag_arr [WB_PORTS];
  logic [XLEN-1:0] wb_val_arr [WB_PORTS];
  logic [WB_PORTS-1:0] wb_en;

  for (genvar gi = 0; gi < WB_PORTS; gi++) begin : g_wb_unpack
    assign wb_tag_arr[gi] = wb_tag[gi*ROB_DEPTH_BIT +: ROB_DEPTH_BIT];
    assign wb_val_arr[gi] = wb_val[gi*XLEN +: XLEN];
    assign wb_en[gi]      = wb_valid[gi] & active;
  end

  // Per-entry view of this cycle's writebacks; later ports override earlier ones.
  logic [DEPTH-1:0] ent_wb_hit;
  logic [XLEN-1:0]  ent_wb_val [DEPTH];

  always_comb begin
    ent_wb_hit = '0;
    for (int e = 0; e < DEPTH; e++) begin
      ent_wb_val[e] = '0;
      for (int p = 0; p < WB_PORTS; p++) begin
        if (wb_en[p] && wb_tag_arr[p] == tag_t'(e)) begin
          ent_wb_hit[e] = 1'b1;
          ent_wb_val[e] = wb_val_arr[p];
        end
      end
    end
  end

  logic [1:0] head_type;
  logic       head_live;
  logic       pop;
  logic       mispredict;
  logic       accept;

  assign head_type  = type_reg[head_reg];
  assign head_live  = busy_reg[head_reg] & ready_reg[head_reg] & active;
  assign pop        = head_live & ((head_type != TYPE_STORE) | st_cmt_ack);
  assign mispredict = pop & (head_type == TYPE_BRANCH)
                    & (val_reg[head_reg][0] != pred_reg[head_reg]);

  // Registered count only: a same-cycle retire never frees a slot for a dispatch at full.
  assign disp_ready = (count_reg < FULL_COUNT);
  assign accept     = disp_valid & disp_ready & active;
  assign disp_tag   = tail_reg;

  assign cmt_valid    = head_live & (head_type == TYPE_RD);
  assign cmt_rd       = rd_reg[head_reg];
  assign cmt_val      = val_reg[head_reg];
  assign cmt_tag      = head_reg;
  assign st_cmt_valid = head_live & (head_type == TYPE_STORE);
  assign st_cmt_tag   = head_reg;

  assign q1_ready = busy_reg[q1_tag] & (ready_reg[q1_tag] | ent_wb_hit[q1_tag]);
  assign q1_val   = ent_wb_hit[q1_tag] ? ent_wb_val[q1_tag] : val_reg[q1_tag];
  assign q2_ready = busy_reg[q2_tag] & (ready_reg[q2_tag] | ent_wb_hit[q2_tag]);
  assign q2_val   = ent_wb_hit[q2_tag] ? ent_wb_val[q2_tag] : val_reg[q2_tag];

  assign flush_out = flush_reg;
  assign flush_pc  = flush_pc_reg;
  assign count     = count_reg;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      busy_reg     <= '0;
      ready_reg    <= '0;
      pred_reg     <= '0;
      head_reg     <= '0;
      tail_reg     <= '0;
      count_reg    <= '0;
      flush_reg    <= 1'b0;
      flush_pc_reg <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        type_reg[i]   <= '0;
        rd_reg[i]     <= '0;
        val_reg[i]    <= '0;
        alt_pc_reg[i] <= '0;
      end
    end else if (rdy_in) begin
      if (flush_reg) begin
        busy_reg  <= '0;
        ready_reg <= '0;
        pred_reg  <= '0;
        head_reg  <= '0;
        tail_reg  <= '0;
        count_reg <= '0;
        flush_reg <= 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
          type_reg[i]   <= '0;
          rd_reg[i]     <= '0;
          val_reg[i]    <= '0;
          alt_pc_reg[i] <= '0;
        end
      end else begin
        for (int p = 0; p < WB_PORTS; p++) begin
          if (wb_en[p] && busy_reg[wb_tag_arr[p]]) begin
            ready_reg[wb_tag_arr[p]] <= 1'b1;
            val_reg[wb_tag_arr[p]]   <= wb_val_arr[p];
          end
        end
        if (pop) begin
          busy_reg[head_reg]  <= 1'b0;
          ready_reg[head_reg] <= 1'b0;
          head_reg            <= head_reg + 1'b1;
        end
        if (accept) begin
          busy_reg[tail_reg]   <= 1'b1;
          ready_reg[tail_reg]  <= disp_done;
          pred_reg[tail_reg]   <= disp_pred;
          type_reg[tail_reg]   <= disp_type;
          rd_reg[tail_reg]     <= disp_rd;
          val_reg[tail_reg]    <= disp_val;
          alt_pc_reg[tail_reg] <= disp_alt_pc;
          tail_reg             <= tail_reg + 1'b1;
        end
        case ({accept, pop})
          2'b10:   count_reg <= count_reg + 1'b1;
          2'b01:   count_reg <= count_reg - 1'b1;
          default: count_reg <= count_reg;
        endcase
        flush_reg <= mispredict;
        if (mispredict) begin
          flush_pc_reg <= alt_pc_reg[head_reg];
        end
      end
    end
  end

endmodule

// File: tb/tb_rob_multiport.sv
// Bench for rob_multiport: a per-cycle vector table, directed multi-cycle sequences, then
// randomized traffic against a queue-based model of the reorder buffer.
module tb_rob_multiport;

  localparam int DEPTH = 16;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, disp_valid, disp_ready, disp_done, disp_pred;
  logic [3:0]  disp_tag, cmt_tag, st_cmt_tag, q1_tag, q2_tag;
  logic [1:0]  disp_type, wb_valid;
  logic [4:0]  disp_rd, cmt_rd, count;
  logic [31:0] disp_val, disp_alt_pc, cmt_val, q1_val, q2_val, flush_pc;
  logic [7:0]  wb_tag;
  logic [63:0] wb_val;
  logic        cmt_valid, st_cmt_valid, st_cmt_ack, q1_ready, q2_ready, flush_out;

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  rob_multiport #(.ROB_DEPTH_BIT(4), .WB_PORTS(2), .XLEN(32)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_tag(disp_tag),
    .disp_type(disp_type), .disp_rd(disp_rd), .disp_done(disp_done), .disp_val(disp_val),
    .disp_pred(disp_pred), .disp_alt_pc(disp_alt_pc),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_val(wb_val),
    .cmt_valid(cmt_valid), .cmt_rd(cmt_rd), .cmt_val(cmt_val), .cmt_tag(cmt_tag),
    .st_cmt_valid(st_cmt_valid), .st_cmt_tag(st_cmt_tag), .st_cmt_ack(st_cmt_ack),
    .q1_tag(q1_tag), .q2_tag(q2_tag), .q1_ready(q1_ready), .q2_ready(q2_ready),
    .q1_val(q1_val), .q2_val(q2_val),
    .flush_out(flush_out), .flush_pc(flush_pc), .count(count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic nxt();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    rdy_in = 1'b1; disp_valid = 1'b0; disp_type = 2'd0; disp_rd = 5'd0; disp_done = 1'b0;
    disp_val = 32'd0; disp_pred = 1'b0; disp_alt_pc = 32'd0;
    wb_valid = 2'b00; wb_tag = 8'd0; wb_val = 64'd0; st_cmt_ack = 1'b0;
    q1_tag = 4'd0; q2_tag = 4'd0;
  endtask

  task automatic disp(input logic [1:0] t, input logic [4:0] rd, input logic done,
                      input logic [31:0] val, input logic pred, input logic [31:0] alt);
    disp_valid = 1'b1; disp_type = t; disp_rd = rd; disp_done = done;
    disp_val = val; disp_pred = pred; disp_alt_pc = alt;
  endtask

  task automatic set_wb(input int p, input logic [3:0] tag, input logic [31:0] val);
    wb_valid[p] = 1'b1;
    wb_tag[p*4 +: 4] = tag;
    wb_val[p*32 +: 32] = val;
  endtask

  // ---------------- per-cycle vector table ----------------
  typedef struct {
    int dv, dt, drd, dd, dval;
    int wbv, t0, v0, t1, v1;
    int qt;
    int e_cnt, e_cv, e_rd, e_val, e_qr, e_qv;
  } vec_t;

  vec_t vecs[18];

  // ---------------- reference model ----------------
  typedef struct {
    int          tag;
    int          typ;
    int          rd;
    bit          done;
    logic [31:0] val;
    bit          pred;
    logic [31:0] alt;
  } ent_t;

  ent_t        mq[$];
  int          m_head, m_tail;
  bit          m_flush;
  logic [31:0] m_fpc;

  function automatic int find_tag(input int tag);
    for (int i = 0; i < mq.size(); i++) if (mq[i].tag == tag) return i;
    return -1;
  endfunction

  function automatic void qlook(input int tag, input bit act, output bit r, output logic [31:0] v);
    int idx = find_tag(tag);
    bit hit = 1'b0;
    logic [31:0] hv = 32'd0;
    for (int p = 0; p < 2; p++) begin
      if (act && wb_valid[p] && int'(wb_tag[p*4 +: 4]) == tag) begin
        hit = 1'b1;
        hv = wb_val[p*32 +: 32];
      end
    end
    r = 1'b0;
    v = 32'd0;
    if (idx >= 0) begin
      r = mq[idx].done || hit;
      v = hit ? hv : mq[idx].val;
    end
  endfunction

  task automatic model_check();
    int sz = mq.size();
    bit act = rdy_in && !m_flush;
    bit live = act && sz > 0 && mq[0].done;
    bit e_cv = live && mq[0].typ == 0;
    bit e_st = live && mq[0].typ == 1;
    bit r;
    logic [31:0] v;
    chk("rand_count", 32'(count), 32'(sz));
    chk("rand_disp_ready", 32'(disp_ready), 32'(sz < DEPTH));
    chk("rand_disp_tag", 32'(disp_tag), 32'(m_tail));
    chk("rand_flush_out", 32'(flush_out), 32'(m_flush));
    if (m_flush) chk("rand_flush_pc", flush_pc, m_fpc);
    chk("rand_cmt_valid", 32'(cmt_valid), 32'(e_cv));
    if (e_cv) begin
      chk("rand_cmt_rd", 32'(cmt_rd), 32'(mq[0].rd));
      chk("rand_cmt_val", cmt_val, mq[0].val);
      chk("rand_cmt_tag", 32'(cmt_tag), 32'(m_head));
      $display("commit tag %0d rd x%0d val 0x%h", m_head, mq[0].rd, mq[0].val);
    end
    chk("rand_st_valid", 32'(st_cmt_valid), 32'(e_st));
    if (e_st) begin
      chk("rand_st_tag", 32'(st_cmt_tag), 32'(m_head));
      $display("store head tag %0d ack %0d", m_head, st_cmt_ack);
    end
    qlook(int'(q1_tag), act, r, v);
    chk("rand_q1_ready", 32'(q1_ready), 32'(r));
    if (r) chk("rand_q1_val", q1_val, v);
    qlook(int'(q2_tag), act, r, v);
    chk("rand_q2_ready", 32'(q2_ready), 32'(r));
    if (r) chk("rand_q2_val", q2_val, v);
  endtask

  // Applied at the clock edge with the inputs that were presented for that cycle.
  task automatic model_step();
    bit pop, acc, misp;
    ent_t e, n;
    if (!rdy_in) return;
    if (m_flush) begin
      mq.delete();
      m_head = 0; m_tail = 0; m_flush = 1'b0;
      return;
    end
    pop  = mq.size() > 0 && mq[0].done && (mq[0].typ != 1 || st_cmt_ack);
    acc  = disp_valid && mq.size() < DEPTH;
    misp = 1'b0;
    if (pop) begin
      e = mq.pop_front();
      m_head = (m_head + 1) % DEPTH;
      if (e.typ == 2 && e.val[0] != e.pred) begin
        misp = 1'b1;
        m_fpc = e.alt;
      end
    end
    for (int p = 0; p < 2; p++) begin
      if (wb_valid[p]) begin
        int idx = find_tag(int'(wb_tag[p*4 +: 4]));
        if (idx >= 0) begin
          mq[idx].done = 1'b1;
          mq[idx].val = wb_val[p*32 +: 32];
        end
      end
    end
    if (acc) begin
      n.tag = m_tail; n.typ = int'(disp_type); n.rd = int'(disp_rd); n.done = disp_done;
      n.val = disp_val; n.pred = disp_pred; n.alt = disp_alt_pc;
      mq.push_back(n);
      m_tail = (m_tail + 1) % DEPTH;
    end
    m_flush = misp;
  endtask

  initial begin
    //          dv dt drd dd dval  wbv t0 v0      t1 v1       qt  cnt cv rd val      qr qv
    vecs[0]  = '{1, 3, 0, 1, 0,    0, 0, 0,      0, 0,       0,  0, 0, 0, 0,      0, 0};
    vecs[1]  = '{1, 3, 0, 1, 0,    0, 0, 0,      0, 0,       0,  1, 0, 0, 0,      1, 0};
    vecs[2]  = '{1, 3, 0, 1, 0,    0, 0, 0,      0, 0,       1,  1, 0, 0, 0,      1, 0};
    vecs[3]  = '{1, 0, 5, 0, 0,    0, 0, 0,      0, 0,       2,  1, 0, 0, 0,      1, 0};
    vecs[4]  = '{1, 0, 6, 0, 0,    0, 0, 0,      0, 0,       3,  1, 0, 0, 0,      0, 0};
    vecs[5]  = '{0, 0, 0, 0, 0,    3, 4, 'h22,   3, 'h11,    3,  2, 0, 0, 0,      1, 'h11};
    vecs[6]  = '{0, 0, 0, 0, 0,    0, 0, 0,      0, 0,       4,  2, 1, 5, 'h11,   1, 'h22};
    vecs[7]  = '{0, 0, 0, 0, 0,    0, 0, 0,      0, 0,       3,  1, 1, 6, 'h22,   0, 0};
    vecs[8]  = '{1, 0, 7, 0, 0,    0, 0, 0,      0, 0,       0,  0, 0, 0, 0,      0, 0};
    vecs[9]  = '{1, 0, 8, 0, 0,    0, 0, 0,      0, 0,       0,  1, 0, 0, 0,      0, 0};
    vecs[10] = '{1, 0, 9, 0, 0,    0, 0, 0,      0, 0,       0,  2, 0, 0, 0,      0, 0};
    vecs[11] = '{0, 0, 0, 0, 0,    3, 7, 'h1111, 7, 'hABCD,  7,  3, 0, 0, 0,      1, 'hABCD};
    vecs[12] = '{0, 0, 0, 0, 0,    0, 0, 0,      0, 0,       7,  3, 0, 0, 0,      1, 'hABCD};
    vecs[13] = '{0, 0, 0, 0, 0,    3, 5, 'h55,   6, 'h66,    5,  3, 0, 0, 0,      1, 'h55};
    vecs[14] = '{0, 0, 0, 0, 0,    0, 0, 0,      0, 0,       6,  3, 1, 7, 'h55,   1, 'h66};
    vecs[15] = '{0, 0, 0, 0, 0,    0, 0, 0,      0, 0,       7,  2, 1, 8, 'h66,   1, 'hABCD};
    vecs[16] = '{0, 0, 0, 0, 0,    0, 0, 0,      0, 0,       7,  1, 1, 9, 'hABCD, 1, 'hABCD};
    vecs[17] = '{0, 0, 0, 0, 0,    0, 0, 0,      0, 0,       7,  0, 0, 0, 0,      0, 0};

    // Reset state
    idle();
    rst_in = 1'b1;
    #12;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_disp_ready", 32'(disp_ready), 32'd1);
    chk("rst_disp_tag", 32'(disp_tag), 32'd0);
    chk("rst_cmt_valid", 32'(cmt_valid), 32'd0);
    chk("rst_cmt_val", cmt_val, 32'd0);
    chk("rst_st_valid", 32'(st_cmt_valid), 32'd0);
    chk("rst_flush_out", 32'(flush_out), 32'd0);
    chk("rst_flush_pc", flush_pc, 32'd0);
    chk("rst_q1_ready", 32'(q1_ready), 32'd0);
    $display("reset: count=%0d disp_ready=%0d", count, disp_ready);
    @(negedge clk_in);
    rst_in = 1'b0;
    nxt();

    // Vector table: multi-port writeback ordering, commit order, query bypass
    for (int i = 0; i < 18; i++) begin
      idle();
      if (vecs[i].dv != 0)
        disp(2'(vecs[i].dt), 5'(vecs[i].drd), 1'(vecs[i].dd), 32'(vecs[i].dval), 1'b0, 32'd0);
      if (vecs[i].wbv % 2 == 1) set_wb(0, 4'(vecs[i].t0), 32'(vecs[i].v0));
      if (vecs[i].wbv / 2 == 1) set_wb(1, 4'(vecs[i].t1), 32'(vecs[i].v1));
      q1_tag = 4'(vecs[i].qt);
      q2_tag = 4'(vecs[i].qt);
      @(negedge clk_in);
      chk("vec_count", 32'(count), 32'(vecs[i].e_cnt));
      chk("vec_cmt_valid", 32'(cmt_valid), 32'(vecs[i].e_cv));
      if (vecs[i].e_cv != 0) begin
        chk("vec_cmt_rd", 32'(cmt_rd), 32'(vecs[i].e_rd));
        chk("vec_cmt_val", cmt_val, 32'(vecs[i].e_val));
      end
      chk("vec_q1_ready", 32'(q1_ready), 32'(vecs[i].e_qr));
      chk("vec_q2_ready", 32'(q2_ready), 32'(vecs[i].e_qr));
      if (vecs[i].e_qr != 0) chk("vec_q1_val", q1_val, 32'(vecs[i].e_qv));
      $display("vec %0d: count=%0d cmt_valid=%0d cmt_rd=%0d q1_ready=%0d q1_val=0x%0h",
               i, count, cmt_valid, cmt_rd, q1_ready, q1_val);
      nxt();
    end

    // Store at head held until acknowledged (head tag 8)
    idle();
    disp(2'd1, 5'd0, 1'b1, 32'd0, 1'b0, 32'd0);
    @(negedge clk_in);
    chk("st_count0", 32'(count), 32'd0);
    nxt();
    idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      chk("st_hold_valid", 32'(st_cmt_valid), 32'd1);
      chk("st_hold_tag", 32'(st_cmt_tag), 32'd8);
      chk("st_hold_count", 32'(count), 32'd1);
      chk("st_hold_cmt_valid", 32'(cmt_valid), 32'd0);
      $display("store wait %0d: st_cmt_valid=%0d tag=%0d", i, st_cmt_valid, st_cmt_tag);
      nxt();
    end
    st_cmt_ack = 1'b1;
    @(negedge clk_in);
    chk("st_ack_valid", 32'(st_cmt_valid), 32'd1);
    nxt();
    idle();
    @(negedge clk_in);
    chk("st_pop_count", 32'(count), 32'd0);
    chk("st_pop_valid", 32'(st_cmt_valid), 32'd0);
    $display("store acked: count=%0d", count);
    nxt();

    // Mispredicted branch (tag 9) followed by a ready RD that must be discarded
    disp(2'd2, 5'd0, 1'b0, 32'd0, 1'b1, 32'h1000);
    @(negedge clk_in);
    chk("br_count0", 32'(count), 32'd0);
    nxt();
    idle();
    disp(2'd0, 5'd3, 1'b1, 32'h77, 1'b0, 32'd0);
    @(negedge clk_in);
    chk("br_count1", 32'(count), 32'd1);
    nxt();
    idle();
    set_wb(0, 4'd9, 32'd0);
    @(negedge clk_in);
    chk("br_count2", 32'(count), 32'd2);
    chk("br_flush_pre", 32'(flush_out), 32'd0);
    nxt();
    idle();
    @(negedge clk_in);
    chk("br_flush_retire", 32'(flush_out), 32'd0);
    chk("br_retire_cmt", 32'(cmt_valid), 32'd0);
    nxt();
    idle();
    disp(2'd0, 5'd4, 1'b1, 32'h88, 1'b0, 32'd0);
    @(negedge clk_in);
    chk("br_flush_out", 32'(flush_out), 32'd1);
    chk("br_flush_pc", flush_pc, 32'h1000);
    chk("br_flush_cmt", 32'(cmt_valid), 32'd0);
    $display("flush: flush_out=%0d flush_pc=0x%0h", flush_out, flush_pc);
    nxt();
    idle();
    @(negedge clk_in);
    chk("br_flush_end", 32'(flush_out), 32'd0);
    chk("br_count_after", 32'(count), 32'd0);
    chk("br_tail_after", 32'(disp_tag), 32'd0);
    nxt();

    // Fill to 16, then a retire in the same cycle as a dispatch attempt at full
    for (int i = 0; i < 16; i++) begin
      idle();
      disp(2'd0, 5'(i), 1'b0, 32'd0, 1'b0, 32'd0);
      @(negedge clk_in);
      chk("fill_ready", 32'(disp_ready), 32'd1);
      chk("fill_tag", 32'(disp_tag), 32'(i));
      $display("fill %0d: disp_tag=%0d count=%0d", i, disp_tag, count);
      nxt();
    end
    idle();
    disp(2'd0, 5'd20, 1'b1, 32'h5, 1'b0, 32'd0);
    set_wb(0, 4'd0, 32'h300);
    @(negedge clk_in);
    chk("full_ready", 32'(disp_ready), 32'd0);
    chk("full_count", 32'(count), 32'd16);
    nxt();
    wb_valid = 2'b00;
    @(negedge clk_in);
    chk("full_retire_ready", 32'(disp_ready), 32'd0);
    chk("full_retire_cmt", 32'(cmt_valid), 32'd1);
    chk("full_retire_tag", 32'(cmt_tag), 32'd0);
    chk("full_retire_count", 32'(count), 32'd16);
    nxt();
    @(negedge clk_in);
    chk("wrap_ready", 32'(disp_ready), 32'd1);
    chk("wrap_count", 32'(count), 32'd15);
    chk("wrap_tag", 32'(disp_tag), 32'd0);
    nxt();
    idle();
    @(negedge clk_in);
    chk("wrap_count_after", 32'(count), 32'd16);
    chk("wrap_tag_after", 32'(disp_tag), 32'd1);
    $display("wrap: count=%0d disp_tag=%0d", count, disp_tag);

    // Stall: head ready but rdy_in low for 5 cycles with traffic present
    set_wb(1, 4'd1, 32'h99);
    nxt();
    for (int i = 0; i < 5; i++) begin
      idle();
      rdy_in = 1'b0;
      disp(2'd0, 5'd1, 1'b1, 32'h1, 1'b0, 32'd0);
      set_wb(0, 4'd2, 32'h42);
      st_cmt_ack = 1'b1;
      @(negedge clk_in);
      chk("stall_cmt", 32'(cmt_valid), 32'd0);
      chk("stall_count", 32'(count), 32'd16);
      chk("stall_tag", 32'(disp_tag), 32'd1);
      $display("stall %0d: count=%0d cmt_valid=%0d", i, count, cmt_valid);
      nxt();
    end
    idle();
    @(negedge clk_in);
    chk("resume_cmt", 32'(cmt_valid), 32'd1);
    chk("resume_val", cmt_val, 32'h99);
    chk("resume_tag", 32'(cmt_tag), 32'd1);
    chk("resume_count", 32'(count), 32'd16);
    nxt();
    q1_tag = 4'd2;
    @(negedge clk_in);
    chk("stall_wb_dropped", 32'(cmt_valid), 32'd0);
    chk("stall_wb_q", 32'(q1_ready), 32'd0);
    chk("post_stall_count", 32'(count), 32'd15);
    nxt();

    // Asynchronous reset mid-cycle
    q1_tag = 4'd0;
    #1;
    chk("pre_rst_q1", 32'(q1_ready), 32'd1);
    #1;
    rst_in = 1'b1;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_disp_ready", 32'(disp_ready), 32'd1);
    chk("arst_disp_tag", 32'(disp_tag), 32'd0);
    chk("arst_q1", 32'(q1_ready), 32'd0);
    chk("arst_cmt", 32'(cmt_valid), 32'd0);
    chk("arst_flush", 32'(flush_out), 32'd0);
    $display("async reset: count=%0d disp_ready=%0d", count, disp_ready);
    rst_in = 1'b0;
    #2;

    // Randomized traffic against the model
    mq.delete();
    m_head = 0; m_tail = 0; m_flush = 1'b0; m_fpc = 32'd0;
    nxt();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      idle();
      rdy_in      = ($urandom_range(0, 9) != 0);
      disp_valid  = ($urandom_range(0, 3) != 0);
      disp_type   = 2'($urandom_range(0, 3));
      disp_rd     = 5'($urandom);
      disp_done   = ($urandom_range(0, 3) == 0);
      disp_val    = $urandom;
      disp_pred   = 1'($urandom);
      disp_alt_pc = $urandom;
      for (int p = 0; p < 2; p++) begin
        int t;
        if (mq.size() > 0 && $urandom_range(0, 3) != 0)
          t = mq[$urandom_range(0, mq.size() - 1)].tag;
        else
          t = int'($urandom_range(0, 15));
        wb_valid[p] = ($urandom_range(0, 9) < 4);
        wb_tag[p*4 +: 4] = 4'(t);
        wb_val[p*32 +: 32] = $urandom;
      end
      st_cmt_ack = ($urandom_range(0, 2) == 0);
      if (mq.size() > 0 && $urandom_range(0, 1) == 0)
        q1_tag = 4'(mq[$urandom_range(0, mq.size() - 1)].tag);
      else
        q1_tag = 4'($urandom);
      q2_tag = wb_tag[3:0];
      @(negedge clk_in);
      model_check();
      @(posedge clk_in);
      model_step();
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
